clock_mode_sequencer: RTL and testbench
=======================================

// Module: clock_mode_sequencer
// PURPOSE
//  Central mode controller for the digital clock/alarm datapath. Sequences RUN, SET_TIME,
//  SET_ALARM and RING from debounced buttons and a slow tick. Issues one-cycle increment
//  strobes to the sec/min/hour counters (time or alarm bank), freezes timekeeping while
//  setting, selects the display bank and drives the alarm ring output. Sits between the
//  debouncers / clock divider and the counter, BCD and display-mux blocks.
// PARAMETERS
//  IDLE_TIMEOUT   80   ticks with no button edge in a SET state before auto-return to RUN
//  REPEAT_DELAY   4    ticks inc_btn must stay held before auto-repeat starts
//  REPEAT_PERIOD  1    ticks between auto-repeat strobes (>=1)
//  RING_TICKS     480  ticks RING lasts without acknowledge
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  RESETn      in   1  asynchronous active-low reset
//  tick        in   1  one-clk-wide strobe from divider (~8 Hz); sole timebase for counts
//  mode_btn    in   1  debounced, synchronous level; rising edge = next mode
//  set_btn     in   1  debounced level; rising edge = next field
//  inc_btn     in   1  debounced level; rising edge / hold = increment
//  alarm_hit   in   1  one-clk pulse: time equals alarm
//  alarm_en    in   1  level; 0 blocks entry to RING
//  mode_state  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RING
//  field_sel   out  2  0 sec, 1 min, 2 hour (3 never driven)
//  inc_time    out  3  one-hot strobe {hour,min,sec} to time counters
//  inc_alarm   out  3  one-hot strobe {hour,min,sec} to alarm counters
//  time_hold   out  1  1 = time counters must not advance on their own
//  show_alarm  out  1  1 = display mux selects alarm bank
//  blink       out  1  toggles every 4 ticks in SET states; 0 otherwise
//  ring        out  1  1 while in RING
// BEHAVIOUR
//  Reset (async): state RUN, field_sel 0, all strobes 0, time_hold/show_alarm/blink/ring 0,
//   counters 0; edge-detect history regs reset to 1 so a button held through reset never fires.
//  Edge detect: rise = btn & ~btn_q, one cycle; outputs registered, 1 clk after the rise.
//  Transitions (priority top-down, one per cycle):
//   RUN:       alarm_hit & alarm_en -> RING (wins over mode rise); mode rise -> SET_TIME.
//   SET_TIME:  mode rise -> SET_ALARM; idle count == IDLE_TIMEOUT -> RUN.
//   SET_ALARM: mode rise -> RUN; idle count == IDLE_TIMEOUT -> RUN.
//   RING:      rise on any button -> RUN (ack, edge consumed); ring count == RING_TICKS -> RUN.
//  alarm_hit outside RUN is ignored, not latched.
//  Entering SET_TIME or SET_ALARM: field_sel := 0, idle/repeat/blink counters := 0.
//  set_btn rise in SET state: field_sel 0->1->2->0 (wrap).
//  Increment, SET states only: inc_btn rise -> one strobe on bit field_sel of the active bank
//   (inc_time in SET_TIME, inc_alarm in SET_ALARM). While held, repeat counter counts ticks;
//   at REPEAT_DELAY one strobe, then every REPEAT_PERIOD ticks. Release clears repeat counter.
//   Strobes always one-hot, 1 clk wide, never both banks. Same-cycle mode rise suppresses
//   inc/set action (mode wins); same-cycle set+inc rise: field advances, no strobe.
//  Idle counter: +1 per tick in SET states, cleared on any button rise; saturates, never wraps.
//  time_hold = (state==SET_TIME); show_alarm = (state==SET_ALARM); ring = (state==RING).
//  Counter widths $clog2(param+1); no tick in a cycle means no counter change.
// TESTING
//  Reset with mode_btn held high, release -> stays RUN, no strobe until btn drops and rises.
//  mode rise x3 -> mode_state 01,10,00; show_alarm 1 only in 10; time_hold 1 only in 01.
//  SET_TIME, set rise x2, inc rise -> inc_time=3'b100 for 1 clk; set rise once more -> field 0.
//  SET_ALARM, inc held 7 ticks -> inc_alarm strobes at press, tick 4, 5, 6, 7 (5 total).
//  RUN, alarm_en=1, alarm_hit+mode rise same clk -> RING; 480 ticks -> RUN; repeat, inc rise -> RUN.
//  SET_TIME idle 80 ticks -> RUN; button at tick 79 restarts count; alarm_hit in SET ignored.

Source files
------------

// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer: central mode controller for the clock/alarm datapath.
// Sequences RUN, SET_TIME, SET_ALARM and RING from debounced buttons and the slow
// tick. Issues one-cycle increment strobes to the time or alarm counter bank, freezes
// timekeeping while setting, selects the display bank and drives the ring output.
//
// Ports:
//   clk         system clock, all logic on posedge
//   RESETn      asynchronous active-low reset
//   tick        one-clk strobe from the divider; the only timebase for counts
//   mode_btn    debounced level; rising edge = next mode
//   set_btn     debounced level; rising edge = next field
//   inc_btn     debounced level; rising edge or hold = increment
//   alarm_hit   one-clk pulse: time equals alarm
//   alarm_en    level; 0 blocks entry to RING
//   mode_state  00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RING
//   field_sel   0 sec, 1 min, 2 hour
//   inc_time    one-hot {hour,min,sec} strobe to the time counters
//   inc_alarm   one-hot {hour,min,sec} strobe to the alarm counters
//   time_hold   time counters must not advance on their own
//   show_alarm  display mux selects the alarm bank
//   blink       toggles every 4 ticks in SET states, 0 otherwise
//   ring        high while in RING
module clock_mode_sequencer #(
    parameter int unsigned IDLE_TIMEOUT  = 80,
    parameter int unsigned REPEAT_DELAY  = 4,
    parameter int unsigned REPEAT_PERIOD = 1,
    parameter int unsigned RING_TICKS    = 480
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       alarm_hit,
    input  logic       alarm_en,
    output logic [1:0] mode_state,
    output logic [1:0] field_sel,
    output logic [2:0] inc_time,
    output logic [2:0] inc_alarm,
    output logic       time_hold,
    output logic       show_alarm,
    output logic       blink,
    output logic       ring
);

    localparam int unsigned RepMax =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned RepW   = $clog2(RepMax + 1);
    localparam int unsigned RingW  = $clog2(RING_TICKS + 1);

    localparam logic [IdleW-1:0] IdleLimit = IdleW'(IDLE_TIMEOUT);
    localparam logic [RepW-1:0]  RepDelay  = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0]  RepPeriod = RepW'(REPEAT_PERIOD);
    localparam logic [RingW-1:0] RingLimit = RingW'(RING_TICKS);

    // Encoding matches the mode_state output code directly.
    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StSetTime  = 2'b01,
        StSetAlarm = 2'b10,
        StRing     = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, set_q, inc_q;
    logic [1:0]       field_q, field_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             rep_armed_q, rep_armed_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [1:0]       blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic [2:0]       inc_time_q, inc_time_d;
    logic [2:0]       inc_alarm_q, inc_alarm_d;

    logic             mode_rise, set_rise, inc_rise, any_rise;
    logic             enter_set, strobe, next_in_set;
    logic [RepW-1:0]  rep_inc, rep_thr;

    assign mode_rise = mode_btn & ~mode_q;
    assign set_rise  = set_btn & ~set_q;
    assign inc_rise  = inc_btn & ~inc_q;
    assign any_rise  = mode_rise | set_rise | inc_rise;

    // Before the first repeat strobe the hold must reach REPEAT_DELAY ticks; after it,
    // the same counter restarts and fires every REPEAT_PERIOD ticks.
    assign rep_inc = rep_q + RepW'(1);
    assign rep_thr = rep_armed_q ? RepPeriod : RepDelay;

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        idle_d      = idle_q;
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
        ring_cnt_d  = ring_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        inc_time_d  = 3'b000;
        inc_alarm_d = 3'b000;
        enter_set   = 1'b0;
        strobe      = 1'b0;

        unique case (state_q)
            StRun: begin
                if (alarm_hit && alarm_en) begin
                    state_d    = StRing;
                    ring_cnt_d = '0;
                end else if (mode_rise) begin
                    state_d   = StSetTime;
                    enter_set = 1'b1;
                end
            end

            StSetTime, StSetAlarm: begin
                if (mode_rise) begin
                    // Mode wins over any same-cycle set/inc action.
                    if (state_q == StSetTime) begin
                        state_d   = StSetAlarm;
                        enter_set = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end else if (idle_q == IdleLimit) begin
                    state_d = StRun;
                end else begin
                    if (set_rise || inc_rise) begin
                        idle_d = '0;
                    end else if (tick && (idle_q != IdleLimit)) begin
                        idle_d = idle_q + IdleW'(1);
                    end

                    if (tick) begin
                        if (blink_cnt_q == 2'd3) begin
                            blink_cnt_d = 2'd0;
                            blink_d     = ~blink_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 2'd1;
                        end
                    end

                    if (set_rise) begin
                        field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                    end

                    if (inc_rise) begin
                        rep_d       = '0;
                        rep_armed_d = 1'b0;
                        strobe      = 1'b1;
                    end else if (!inc_btn) begin
                        rep_d       = '0;
                        rep_armed_d = 1'b0;
                    end else if (tick) begin
                        if (rep_inc == rep_thr) begin
                            rep_d       = '0;
                            rep_armed_d = 1'b1;
                            strobe      = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end

                    // A same-cycle field change swallows the strobe.
                    if (strobe && !set_rise) begin
                        if (state_q == StSetTime) begin
                            inc_time_d = 3'b001 << field_q;
                        end else begin
                            inc_alarm_d = 3'b001 << field_q;
                        end
                    end
                end
            end

            StRing: begin
                if (any_rise) begin
                    state_d = StRun;
                end else if (ring_cnt_q == RingLimit) begin
                    state_d = StRun;
                end else if (tick) begin
                    ring_cnt_d = ring_cnt_q + RingW'(1);
                end
            end

            default: state_d = StRun;
        endcase

        if (enter_set) begin
            field_d     = 2'd0;
            idle_d      = '0;
            rep_d       = '0;
            rep_armed_d = 1'b0;
            blink_cnt_d = 2'd0;
            blink_d     = 1'b0;
        end

        next_in_set = (state_d == StSetTime) || (state_d == StSetAlarm);
        if (!next_in_set) begin
            blink_d     = 1'b0;
            blink_cnt_d = 2'd0;
            rep_d       = '0;
            rep_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StRun;
            // History starts high so a button held through reset never fires.
            mode_q      <= 1'b1;
            set_q       <= 1'b1;
            inc_q       <= 1'b1;
            field_q     <= 2'd0;
            idle_q      <= '0;
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
            ring_cnt_q  <= '0;
            blink_cnt_q <= 2'd0;
            blink_q     <= 1'b0;
            inc_time_q  <= 3'b000;
            inc_alarm_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_btn;
            set_q       <= set_btn;
            inc_q       <= inc_btn;
            field_q     <= field_d;
            idle_q      <= idle_d;
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
            ring_cnt_q  <= ring_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            inc_time_q  <= inc_time_d;
            inc_alarm_q <= inc_alarm_d;
        end
    end

    assign mode_state = state_q;
    assign field_sel  = field_q;
    assign inc_time   = inc_time_q;
    assign inc_alarm  = inc_alarm_q;
    assign time_hold  = (state_q == StSetTime);
    assign show_alarm = (state_q == StSetAlarm);
    assign blink      = blink_q;
    assign ring       = (state_q == StRing);

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Bench for clock_mode_sequencer: directed scenarios followed by random button, tick
// and alarm traffic, all checked every cycle against a behavioural model.
module tb_clock_mode_sequencer;

    localparam int IdleTimeout  = 80;
    localparam int RepeatDelay  = 4;
    localparam int RepeatPeriod = 1;
    localparam int RingTicks    = 480;

    logic       clk = 1'b0;
    logic       RESETn;
    logic       tick, mode_btn, set_btn, inc_btn, alarm_hit, alarm_en;
    logic [1:0] mode_state, field_sel;
    logic [2:0] inc_time, inc_alarm;
    logic       time_hold, show_alarm, blink, ring;

    clock_mode_sequencer #(
        .IDLE_TIMEOUT (IdleTimeout),
        .REPEAT_DELAY (RepeatDelay),
        .REPEAT_PERIOD(RepeatPeriod),
        .RING_TICKS   (RingTicks)
    ) dut (
        .clk       (clk),
        .RESETn    (RESETn),
        .tick      (tick),
        .mode_btn  (mode_btn),
        .set_btn   (set_btn),
        .inc_btn   (inc_btn),
        .alarm_hit (alarm_hit),
        .alarm_en  (alarm_en),
        .mode_state(mode_state),
        .field_sel (field_sel),
        .inc_time  (inc_time),
        .inc_alarm (inc_alarm),
        .time_hold (time_hold),
        .show_alarm(show_alarm),
        .blink     (blink),
        .ring      (ring)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 RING.
    int         m_mode, m_field, m_idle, m_ring, m_held, m_set_ticks;
    logic       m_pm, m_ps, m_pi;
    logic [2:0] m_inc_t, m_inc_a;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_idle = 0; m_ring = 0; m_held = 0; m_set_ticks = 0;
        m_pm = 1'b1; m_ps = 1'b1; m_pi = 1'b1;
        m_inc_t = 3'b000; m_inc_a = 3'b000;
    endtask

    task automatic model_enter_set(input int md);
        m_mode = md; m_field = 0; m_idle = 0; m_held = 0; m_set_ticks = 0;
    endtask

    task automatic model_step();
        logic mr, sr, ir;
        bit   fire;
        mr = mode_btn && !m_pm;
        sr = set_btn && !m_ps;
        ir = inc_btn && !m_pi;
        m_pm = mode_btn; m_ps = set_btn; m_pi = inc_btn;
        m_inc_t = 3'b000;
        m_inc_a = 3'b000;
        case (m_mode)
            0: begin
                if (alarm_hit && alarm_en) begin
                    m_mode = 3;
                    m_ring = 0;
                end else if (mr) begin
                    model_enter_set(1);
                end
            end
            1, 2: begin
                if (mr) begin
                    if (m_mode == 1) model_enter_set(2);
                    else m_mode = 0;
                end else if (m_idle >= IdleTimeout) begin
                    m_mode = 0;
                end else begin
                    if (sr || ir) m_idle = 0;
                    else if (tick) m_idle++;
                    if (tick) m_set_ticks++;
                    if (sr) m_field = (m_field + 1) % 3;
                    fire = 0;
                    if (ir) begin
                        m_held = 0;
                        fire = 1;
                    end else if (inc_btn) begin
                        if (tick) begin
                            m_held++;
                            fire = (m_held >= RepeatDelay) &&
                                   ((m_held - RepeatDelay) % RepeatPeriod == 0);
                        end
                    end else begin
                        m_held = 0;
                    end
                    if (fire && !sr) begin
                        if (m_mode == 1) m_inc_t = 3'(1 << m_field);
                        else m_inc_a = 3'(1 << m_field);
                    end
                end
            end
            default: begin
                if (mr || sr || ir) m_mode = 0;
                else if (m_ring >= RingTicks) m_mode = 0;
                else if (tick) m_ring++;
            end
        endcase
    endtask

    task automatic compare_all();
        bit in_set;
        in_set = (m_mode == 1) || (m_mode == 2);
        check("mode_state", {1'b0, mode_state}, 3'(m_mode));
        check("field_sel", {1'b0, field_sel}, 3'(m_field));
        check("inc_time", inc_time, m_inc_t);
        check("inc_alarm", inc_alarm, m_inc_a);
        check("time_hold", {2'b00, time_hold}, {2'b00, m_mode == 1});
        check("show_alarm", {2'b00, show_alarm}, {2'b00, m_mode == 2});
        check("blink", {2'b00, blink}, {2'b00, in_set && ((m_set_ticks / 4) % 2 == 1)});
        check("ring", {2'b00, ring}, {2'b00, m_mode == 3});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input int pct);
        for (int k = 0; k < n; k++) begin
            tick = (int'($urandom_range(99)) < pct);
            step();
        end
        tick = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
    endtask

    task automatic press_set();
        set_btn = 1'b1; step(); set_btn = 1'b0; step();
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
    endtask

    task automatic random_phase(input int n, input int tick_pct, input int mode_pm,
                                input int btn_pm);
        for (int c = 0; c < n; c++) begin
            if (int'($urandom_range(999)) < mode_pm) mode_btn = ~mode_btn;
            if (int'($urandom_range(999)) < btn_pm) set_btn = ~set_btn;
            if (int'($urandom_range(999)) < btn_pm) inc_btn = ~inc_btn;
            if ($urandom_range(499) == 0) alarm_en = ~alarm_en;
            alarm_hit = ($urandom_range(149) == 0);
            tick = (int'($urandom_range(99)) < tick_pct);
            step();
        end
        tick = 1'b0; alarm_hit = 1'b0;
        mode_btn = 1'b0; set_btn = 1'b0; inc_btn = 1'b0;
    endtask

    initial begin
        RESETn = 1'b0;
        tick = 1'b0; mode_btn = 1'b1; set_btn = 1'b0; inc_btn = 1'b0;
        alarm_hit = 1'b0; alarm_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        RESETn = 1'b1;

        // mode held through reset must not fire; then three mode presses
        run(6, 50);
        mode_btn = 1'b0; step();
        press_mode(); press_mode(); press_mode();

        // SET_TIME: hour field strobe, then field wraps to sec
        press_mode();
        press_set(); press_set();
        press_inc();
        press_set();
        set_btn = 1'b1; inc_btn = 1'b1; step();
        set_btn = 1'b0; inc_btn = 1'b0; step();

        // SET_ALARM: inc held for 7 ticks
        press_mode();
        inc_btn = 1'b1; step();
        for (int k = 0; k < 7; k++) begin
            tick = 1'b1; step(); tick = 1'b0; step(); step();
        end
        inc_btn = 1'b0; step();
        press_mode();

        // RING entered with simultaneous mode rise, then timeout, then ack by inc
        alarm_en = 1'b1; step();
        alarm_hit = 1'b1; mode_btn = 1'b1; step();
        alarm_hit = 1'b0; mode_btn = 1'b0; step();
        run(RingTicks + 5, 100);
        alarm_hit = 1'b1; step(); alarm_hit = 1'b0;
        run(10, 50);
        press_inc();

        // SET_TIME idle timeout, restarted by a press at tick 79; alarm ignored
        press_mode();
        run(IdleTimeout - 1, 100);
        press_set();
        alarm_hit = 1'b1; step(); alarm_hit = 1'b0;
        run(IdleTimeout + 5, 100);

        random_phase(8000, 30, 15, 40);
        random_phase(8000, 100, 4, 10);
        random_phase(3000, 60, 30, 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
